acc_ctrl: RTL and testbench
===========================

ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_load  input  1  1 = load cmd_data into accumulator, ignoring cmd_op.
REQ-007 SHALL have port cmd_op  input  3  ALU operation code, OPSEL_* encoding from alu_opsel.vh.
REQ-008 SHALL have port cmd_data  input  32  second operand, or load value.
REQ-009 SHALL have port alu_a  output  32  ALU operand A, always equal to the accumulator.
REQ-010 SHALL have port alu_b  output  32  ALU operand B, the latched operand register.
REQ-011 SHALL have port alu_opsel  output  3  ALU operation select.
REQ-012 SHALL have port alu_r  input  32  combinational ALU result.
REQ-013 SHALL have port res_valid  output  1  result available downstream.
REQ-014 SHALL have port res_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port res_data  output  32  accumulator value after the operation.
REQ-016 SHALL have port op_count  output  CNT_W  number of completed result handshakes.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&&cmd_ready latches cmd_load, cmd_op and cmd_data, and the FSM moves to EXEC.
REQ-019 SHALL drive alu_opsel=latched op in EXEC and OPSEL_NONE in IDLE and RESP.
REQ-020 SHALL update the accumulator at the end of EXEC: load=1 -> acc=operand; op=OPSEL_NONE or an unused code -> acc unchanged; otherwise acc=alu_r. The FSM then moves to RESP.
REQ-021 SHALL drive res_valid=1 in RESP only, with res_data=acc held stable until res_ready.
REQ-022 SHALL complete the result handshake when res_valid&&res_ready; the FSM returns to IDLE and op_count increments by 1.
REQ-023 SHALL wrap op_count modulo 2^CNT_W (all-ones+1 -> 0).
REQ-024 SHALL accept a new command no earlier than the cycle after the result handshake: no overlap, and a minimum of 3 cycles per command.
REQ-025 SHALL ignore cmd_valid outside IDLE and SHALL NOT alter the latched operands.
REQ-026 SHALL perform 32-bit arithmetic with wrap-around; carry and borrow are discarded.

Reset
REQ-027 SHALL, on reset assertion, immediately force: FSM=IDLE, acc=0, operand=0, op=OPSEL_NONE, op_count=0, cmd_ready=1 (once released), res_valid=0, res_data=0, alu_opsel=OPSEL_NONE.
REQ-028 SHALL abort any in-flight EXEC/RESP on reset with no accumulator update and no count.

Configuration
REQ-029 SHALL, with macro ACC_FLAGS_EN defined, add outputs res_zero (acc==0) and res_neg (acc[31]), both valid with res_valid and reset to 0.
REQ-030 SHALL, without ACC_FLAGS_EN, omit res_zero and res_neg ports and logic; all other behaviour is identical.

Verification
REQ-031 SHALL check: load 5, then ADD 3 with res_ready=1 -> res_data=8, op_count=2, each command exactly 3 cycles.
REQ-032 SHALL check: acc=8, SUB 10 -> res_data=0xFFFFFFFE; with ACC_FLAGS_EN, res_neg=1 and res_zero=0.
REQ-033 SHALL check: res_ready low for 5 cycles in RESP -> res_valid and res_data stable, cmd_ready=0, and cmd_valid pulses ignored.
REQ-034 SHALL check: acc=0x0F0F0F0F, NEG -> 0xF0F0F0F0; then NONE -> acc unchanged and op_count still increments.
REQ-035 SHALL check: reset asserted mid-EXEC -> outputs at reset values that same cycle, acc=0, op_count=0.
REQ-036 SHALL check: CNT_W=2 with 4 commands -> op_count wraps 3 -> 0.

Source files
------------

// File: rtl/acc_ctrl_if.sv
// Command/ALU/result bundle for acc_ctrl. The slave modport is the controller side.
// With ACC_FLAGS_EN defined the bundle also carries the res_zero/res_neg result flags.
interface acc_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_data;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_opsel;
  logic [31:0]      alu_r;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [CNT_W-1:0] op_count;
`ifdef ACC_FLAGS_EN
  logic             res_zero;
  logic             res_neg;
`endif

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, alu_r, res_ready,
    output cmd_ready, alu_a, alu_b, alu_opsel, res_valid, res_data, op_count
`ifdef ACC_FLAGS_EN
    , output res_zero, res_neg
`endif
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, alu_r, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_opsel, res_valid, res_data, op_count
`ifdef ACC_FLAGS_EN
    , input res_zero, res_neg
`endif
  );
endinterface

// File: rtl/acc_ctrl.sv
// Accumulator sequencer around an external combinational ALU: one command in, one result out.
// Optional macro ACC_FLAGS_EN adds res_zero/res_neg result flags.
//
// opsel | operation
// 0     | NONE (accumulator unchanged)
// 1     | ADD  a + b
// 2     | SUB  a - b
// 3     | AND  a & b
// 4     | OR   a | b
// 5     | XOR  a ^ b
// 6     | NEG  ~a
// 7     | unused (accumulator unchanged)
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | ALU driven with the latched op; accumulator updated at the end of the cycle
// RESP  | res_valid high, result held until res_ready
module acc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  acc_ctrl_if.slave bus
);

  localparam logic [2:0] OPSEL_NONE = 3'd0;
  localparam logic [2:0] OPSEL_ADD  = 3'd1;
  localparam logic [2:0] OPSEL_SUB  = 3'd2;
  localparam logic [2:0] OPSEL_AND  = 3'd3;
  localparam logic [2:0] OPSEL_OR   = 3'd4;
  localparam logic [2:0] OPSEL_XOR  = 3'd5;
  localparam logic [2:0] OPSEL_NEG  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_load;
  logic [2:0]       r_op;
  logic [31:0]      r_operand;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_done;
  logic             w_cmd_ready;
  logic             w_res_valid;
  logic [2:0]       w_opsel;
  logic             w_op_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_cmd_ready = 1'b0;
    w_res_valid = 1'b0;
    w_opsel     = OPSEL_NONE;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_opsel = r_op;
        w_next  = S_RESP;
      end
      S_RESP: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Codes outside ADD..NEG leave the accumulator untouched rather than trusting alu_r.
  always_comb begin
    w_op_valid = 1'b0;
    case (r_op)
      OPSEL_ADD, OPSEL_SUB, OPSEL_AND,
      OPSEL_OR,  OPSEL_XOR, OPSEL_NEG: w_op_valid = 1'b1;
      default:                         w_op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load    <= 1'b0;
      r_op      <= OPSEL_NONE;
      r_operand <= 32'h0;
    end else if (w_accept) begin
      r_load    <= bus.cmd_load;
      r_op      <= bus.cmd_op;
      r_operand <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 32'h0;
    end else if (r_state == S_EXEC) begin
      if (r_load) begin
        r_acc <= r_operand;
      end else if (w_op_valid) begin
        r_acc <= bus.alu_r;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_done) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  // cmd_ready is held low while reset is asserted so nothing looks accepted during reset.
  assign bus.cmd_ready = w_cmd_ready & ~reset;
  assign bus.res_valid = w_res_valid;
  assign bus.alu_opsel = w_opsel;
  assign bus.alu_a     = r_acc;
  assign bus.alu_b     = r_operand;
  assign bus.res_data  = r_acc;
  assign bus.op_count  = r_op_count;

`ifdef ACC_FLAGS_EN
  assign bus.res_zero = w_res_valid & (r_acc == 32'h0);
  assign bus.res_neg  = w_res_valid & r_acc[31];
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl: a 16-bit-counter instance for function, a 2-bit one for wrap.
module tb_acc_ctrl;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NEG  = 3'd6;
  localparam logic [2:0] OP_BAD  = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic obs_zero;
  logic obs_neg;

  acc_ctrl_if #(.CNT_W(16)) bus ();
  acc_ctrl_if #(.CNT_W(2))  bus2 ();

  acc_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  acc_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  always #5 clk = ~clk;

  // Reference ALU for the main instance
  always_comb begin
    case (bus.alu_opsel)
      OP_ADD:  bus.alu_r = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_r = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_r = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_r = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_r = bus.alu_a ^ bus.alu_b;
      OP_NEG:  bus.alu_r = ~bus.alu_a;
      default: bus.alu_r = 32'h1234_5678;
    endcase
  end
  assign bus2.alu_r = 32'h0;

  // Issue one command from a negedge and run it to completion with res_ready high.
  task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [31:0] d,
                         output logic [31:0] res, output int cyc);
    int guard;
    guard = 0;
    res = 32'hx;
    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.res_ready = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = 1'b0;
      if (bus.res_valid === 1'b1) begin
        res = bus.res_data;
`ifdef ACC_FLAGS_EN
        obs_zero = bus.res_zero;
        obs_neg  = bus.res_neg;
`endif
      end
    end while (bus.cmd_ready !== 1'b1 && cyc < 50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.alu_opsel !== OP_NONE) begin n_fail++; $display("FAIL rst_opsel: got %0d want 0", bus.alu_opsel); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_checks++; if (bus.res_data !== 32'h0) begin n_fail++; $display("FAIL rst_res_data: got %h want 0", bus.res_data); end
    n_checks++; if (bus.op_count !== 16'h0) begin n_fail++; $display("FAIL rst_op_count: got %0d want 0", bus.op_count); end
    n_checks++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin n_fail++; $display("FAIL rst_alu_ab: got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
`ifdef ACC_FLAGS_EN
    n_checks++; if (bus.res_zero !== 1'b0 || bus.res_neg !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b want 00", bus.res_zero, bus.res_neg); end
`endif
  endtask

  task automatic test_load_add();
    logic [31:0] res;
    int cyc;
    run_cmd(1'b1, OP_NONE, 32'd5, res, cyc);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL load5_res: got %h want 5", res); end
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL load5_cycles: got %0d want 3", cyc); end
    run_cmd(1'b0, OP_ADD, 32'd3, res, cyc);
    n_checks++; if (res !== 32'd8) begin n_fail++; $display("FAIL add3_res: got %h want 8", res); end
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL add3_cycles: got %0d want 3", cyc); end
    n_checks++; if (bus.op_count !== 16'd2) begin n_fail++; $display("FAIL add3_count: got %0d want 2", bus.op_count); end
  endtask

  task automatic test_sub_wrap();
    logic [31:0] res;
    int cyc;
    run_cmd(1'b0, OP_SUB, 32'd10, res, cyc);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub10_res: got %h want fffffffe", res); end
`ifdef ACC_FLAGS_EN
    n_checks++; if (obs_neg !== 1'b1 || obs_zero !== 1'b0) begin n_fail++; $display("FAIL sub10_flags: got z%b n%b want z0 n1", obs_zero, obs_neg); end
`endif
    n_checks++; if (bus.op_count !== 16'd3) begin n_fail++; $display("FAIL sub10_count: got %0d want 3", bus.op_count); end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 32'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0) begin n_fail++; $display("FAIL hold_enter: got v%b %h want v1 0", bus.res_valid, bus.res_data); end
`ifdef ACC_FLAGS_EN
    n_checks++; if (bus.res_zero !== 1'b1 || bus.res_neg !== 1'b0) begin n_fail++; $display("FAIL hold_flags: got z%b n%b want z1 n0", bus.res_zero, bus.res_neg); end
`endif
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_load  = 1'b1;
      bus.cmd_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0 || bus.cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got v%b %h rdy%b want v1 0 rdy0", i, bus.res_valid, bus.res_data, bus.cmd_ready);
      end
      n_checks++; if (bus.alu_b !== 32'd2 || bus.op_count !== 16'd3) begin
        n_fail++; $display("FAIL hold_latched%0d: got b=%h cnt=%0d want b=2 cnt=3", i, bus.alu_b, bus.op_count);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got v%b rdy%b want v0 rdy1", bus.res_valid, bus.cmd_ready); end
    n_checks++; if (bus.op_count !== 16'd4 || bus.alu_a !== 32'h0) begin n_fail++; $display("FAIL hold_after: got cnt=%0d acc=%h want 4 0", bus.op_count, bus.alu_a); end
  endtask

  task automatic test_neg_none();
    logic [31:0] res;
    int cyc;
    run_cmd(1'b1, OP_ADD, 32'h0F0F_0F0F, res, cyc);
    n_checks++; if (res !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL load_pat: got %h want 0f0f0f0f", res); end
    run_cmd(1'b0, OP_NEG, 32'h0, res, cyc);
    n_checks++; if (res !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL neg_res: got %h want f0f0f0f0", res); end
    run_cmd(1'b0, OP_NONE, 32'd123, res, cyc);
    n_checks++; if (res !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL none_res: got %h want f0f0f0f0", res); end
    n_checks++; if (bus.op_count !== 16'd7) begin n_fail++; $display("FAIL none_count: got %0d want 7", bus.op_count); end
    run_cmd(1'b0, OP_BAD, 32'd77, res, cyc);
    n_checks++; if (res !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL badop_res: got %h want f0f0f0f0", res); end
    run_cmd(1'b0, OP_XOR, 32'hFFFF_0000, res, cyc);
    n_checks++; if (res !== 32'h0F0F_F0F0) begin n_fail++; $display("FAIL xor_res: got %h want 0f0ff0f0", res); end
    n_checks++; if (bus.op_count !== 16'd9) begin n_fail++; $display("FAIL xor_count: got %0d want 9", bus.op_count); end
  endtask

  task automatic test_reset_mid_exec();
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 32'd1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.alu_opsel !== OP_ADD) begin n_fail++; $display("FAIL midexec_opsel: got %0d want 1", bus.alu_opsel); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.alu_opsel !== OP_NONE || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midexec_ctrl: got op%0d v%b want op0 v0", bus.alu_opsel, bus.res_valid); end
    n_checks++; if (bus.res_data !== 32'h0 || bus.alu_b !== 32'h0) begin n_fail++; $display("FAIL midexec_data: got %h/%h want 0/0", bus.res_data, bus.alu_b); end
    n_checks++; if (bus.op_count !== 16'h0) begin n_fail++; $display("FAIL midexec_count: got %0d want 0", bus.op_count); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_state: got rdy%b v%b want rdy1 v0", bus.cmd_ready, bus.res_valid); end
    n_checks++; if (bus.alu_a !== 32'h0 || bus.op_count !== 16'h0) begin n_fail++; $display("FAIL postrst_acc: got %h cnt=%0d want 0 0", bus.alu_a, bus.op_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int cyc;
    run_cmd(1'b1, OP_NONE, 32'd1, res, cyc);
    run_cmd(1'b0, OP_ADD, 32'd1, res, cyc);
    run_cmd(1'b0, OP_ADD, 32'd1, res, cyc);
    n_checks++; if (res !== 32'd3 || cyc != 3) begin n_fail++; $display("FAIL b2b_seq: got %h in %0d cycles want 3 in 3", res, cyc); end
    // cmd_valid held high for 6 cycles must admit exactly two commands
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 32'd1;
    bus.res_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.alu_a !== 32'd5 || bus.op_count !== 16'd5) begin n_fail++; $display("FAIL b2b_stream: got acc=%h cnt=%0d want 5 5", bus.alu_a, bus.op_count); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got rdy%b want 1", bus.cmd_ready); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      bus2.cmd_valid = 1'b1;
      bus2.cmd_load  = 1'b1;
      bus2.cmd_op    = OP_NONE;
      bus2.cmd_data  = 32'(k + 10);
      bus2.res_ready = 1'b1;
      @(negedge clk);
      bus2.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus2.op_count !== exp_cnt[k]) begin n_fail++; $display("FAIL wrap_count%0d: got %0d want %0d", k, bus2.op_count, exp_cnt[k]); end
    end
    n_checks++; if (bus2.res_data !== 32'd13) begin n_fail++; $display("FAIL wrap_data: got %h want 0d", bus2.res_data); end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_load   = 1'b0;
    bus.cmd_op     = OP_NONE;
    bus.cmd_data   = 32'h0;
    bus.res_ready  = 1'b0;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_load  = 1'b0;
    bus2.cmd_op    = OP_NONE;
    bus2.cmd_data  = 32'h0;
    bus2.res_ready = 1'b0;
    obs_zero = 1'b0;
    obs_neg  = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_add();
    test_sub_wrap();
    test_backpressure();
    test_neg_none();
    test_reset_mid_exec();
    test_back_to_back();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
